fpu_stall_seq_vliw: RTL and testbench
=====================================

// Module: fpu_stall_seq_vliw
// PURPOSE
// - Multi-cycle FPU sequencer for the E stage of the 4-lane VLIW core. Lanes 1 and 2 are the FPU lanes.
// - Decodes FPU opcodes into per-lane latencies and raises the float stall (StallE/StallF/StallD/FlushM) for the full wait.
// - Latches each FPU lane's result when its latency expires and presents it at release.
// - Snapshots the four writeback lanes into keep registers at issue. These feed the Kept forwarding sources of the hazard unit.
// PARAMETERS
// - DATA_W    32  datapath width
// - REG_W     6   register index width
// - LAT_W     3   latency/counter width
// - LAT_ARITH 1   fadd/fsub/fmul latency
// - LAT_FDIV  3   fdiv latency
// - LAT_FSQRT 2   fsqrt latency
// PORTS
// - clk            in   1          clock
// - rstn           in   1          synchronous, active-low reset
// - issue_i        in   1          E-stage bundle valid (not flushed)
// - fpu_op1_i      in   5          lane1 FPU control; same encoding as FPUControlE
// - fpu_op2_i      in   5          lane2 FPU control
// - fpu_res1_i     in   DATA_W     lane1 FPU core output, valid N1 cycles after issue
// - fpu_res2_i     in   DATA_W     lane2 FPU core output
// - wb_reg_i       in   4*REG_W    writeback dest, lanes 1..4 (M1,M2,W3,W4)
// - wb_we_i        in   4          writeback enables
// - wb_data_i      in   4*DATA_W   writeback data
// - float_stall_o  out  1          stall request to the hazard unit
// - fstalled_o     out  1          keep registers valid
// - read_keep_o    out  1          first stall cycle; BRAM read-data hold
// - keep_reg_o     out  4*REG_W    kept dests
// - keep_we_o      out  4          kept enables
// - keep_data_o    out  4*DATA_W   kept data
// - res1_o         out  DATA_W     lane1 FPU result to the E/M register
// - res2_o         out  DATA_W     lane2 FPU result to the E/M register
// - res_valid_o    out  1          release pulse; results final, E advances
// BEHAVIOUR
// - Latency decode: 00001/00011/00101 -> LAT_ARITH; 00111 -> LAT_FDIV; 01101 -> LAT_FSQRT.
//   All other codes -> 0. Nk = lane k latency; MAXN = max(N1,N2).
// - States: IDLE, BUSY.
// - IDLE, issue_i=1 and MAXN>0:
//   - float_stall_o=1 and read_keep_o=1 (combinational).
//   - At the clock edge: cnt<=1; latch N1, N2, MAXN; keep_*<=wb_*; next state BUSY.
// - IDLE otherwise:
//   - float_stall_o=0; res_k_o = fpu_res_k_i (pass-through).
//   - res_valid_o = issue_i & (MAXN==0).
// - BUSY:
//   - fstalled_o=1 and float_stall_o = (cnt != MAXN_q).
//   - Lane k: when cnt==Nk_q, latch res_k_q<=fpu_res_k_i.
//   - Lanes with Nk_q==0 latch in the issue cycle.
//   - Latched lanes drive res_k_o=res_k_q; an unlatched lane passes fpu_res_k_i through.
//   - cnt!=MAXN_q: cnt++.
//   - cnt==MAXN_q (release cycle): float_stall_o=0; res_valid_o=1; res_k_o=latched value; next state IDLE.
// - Stall length is exactly MAXN cycles, counting from the issue cycle.
// - Opcodes are held stable by StallE, but only the latched copies are used.
// - Back-to-back FPU ops: the bundle after release is seen in IDLE the next cycle. No bubble is inserted and no re-trigger occurs.
// - Keep registers hold their value until the next issue that enters BUSY.
//   fstalled_o is 0 in IDLE, so the hazard unit ignores them there.
// - Keep snapshot ignores wb entries whose reg is 0 (keep_we=0).
// - issue_i is ignored in BUSY.
// - Reset (any time, including mid-BUSY): state=IDLE, cnt=0, all latched/keep regs=0, every output=0 except pass-through res_k_o.
// CONFIGURATION
// - FSTALL_PERF_EN defined:
//   - Adds output perf_fstall_o [31:0]: counts cycles with float_stall_o=1.
//   - Saturates at 2^32-1; cleared by reset.
// - FSTALL_PERF_EN undefined: the port and counter are absent.
// TESTING
// - lane1 fadd (00001), lane2 fneg:
//   - stall=1 in the issue cycle only.
//   - Next cycle release: res_valid=1, res1=value sampled at cnt=1.
// - lane1 fdiv, lane2 fsqrt:
//   - stall high for 3 cycles; read_keep=1 only in the first.
//   - res2 latched at cnt=2, res1 at cnt=3; release on cycle 4.
// - lane1 fneg only: stall never asserted; res_valid=1 same cycle; res1 = fpu_res1_i.
// - Keep capture: wb_reg={5,0,7,9}, we=1111, data={A,B,C,D} at fdiv issue.
//   - keep_we=1011 with data intact through release; fstalled=1 for 3 cycles.
// - Reset mid-BUSY (fdiv, cnt=2):
//   - Next cycle stall=0, fstalled=0, keep_we=0, state IDLE.
//   - A new fadd issue then behaves as in the first scenario.
// - Back-to-back fmul then fdiv: stalls of 1 and 3 cycles separated by one release cycle.
//   - FSTALL_PERF_EN: perf_fstall_o=4.

Source files
------------

// File: rtl/fpu_stall_seq_vliw.sv
// Multi-cycle FPU sequencer for the VLIW E stage (lanes 1 and 2 are FPU lanes).
// Optional FSTALL_PERF_EN adds perf_fstall_o, a saturating stall-cycle counter.
module fpu_stall_seq_vliw #(
  parameter int DATA_W    = 32,
  parameter int REG_W     = 6,
  parameter int LAT_W     = 3,
  parameter int LAT_ARITH = 1,
  parameter int LAT_FDIV  = 3,
  parameter int LAT_FSQRT = 2
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                issue_i,
  input  logic [4:0]          fpu_op1_i,
  input  logic [4:0]          fpu_op2_i,
  input  logic [DATA_W-1:0]   fpu_res1_i,
  input  logic [DATA_W-1:0]   fpu_res2_i,
  input  logic [4*REG_W-1:0]  wb_reg_i,
  input  logic [3:0]          wb_we_i,
  input  logic [4*DATA_W-1:0] wb_data_i,
  output logic                float_stall_o,
  output logic                fstalled_o,
  output logic                read_keep_o,
  output logic [4*REG_W-1:0]  keep_reg_o,
  output logic [3:0]          keep_we_o,
  output logic [4*DATA_W-1:0] keep_data_o,
  output logic [DATA_W-1:0]   res1_o,
  output logic [DATA_W-1:0]   res2_o,
  output logic                res_valid_o
`ifdef FSTALL_PERF_EN
  ,
  output logic [31:0]         perf_fstall_o
`endif
);

  typedef enum logic {
    S_IDLE,
    S_BUSY
  } state_t;

  state_t              r_state;
  logic [LAT_W-1:0]    r_cnt;
  logic [LAT_W-1:0]    r_n1;
  logic [LAT_W-1:0]    r_n2;
  logic [LAT_W-1:0]    r_maxn;
  logic [DATA_W-1:0]   r_res1;
  logic [DATA_W-1:0]   r_res2;
  logic [4*REG_W-1:0]  r_keep_reg;
  logic [3:0]          r_keep_we;
  logic [4*DATA_W-1:0] r_keep_data;

  logic [LAT_W-1:0]    w_n1;
  logic [LAT_W-1:0]    w_n2;
  logic [LAT_W-1:0]    w_maxn;
  logic                w_start;
  logic                w_lat1;
  logic                w_lat2;
  logic                w_release;
  logic [3:0]          w_keep_we;

  function automatic logic [LAT_W-1:0] f_lat(input logic [4:0] op);
    logic [LAT_W-1:0] v;
    v = '0;
    unique case (op)
      5'b00001,
      5'b00011,
      5'b00101: v = LAT_W'(LAT_ARITH);
      5'b00111: v = LAT_W'(LAT_FDIV);
      5'b01101: v = LAT_W'(LAT_FSQRT);
      default:  v = '0;
    endcase
    return v;
  endfunction

  assign w_n1    = f_lat(fpu_op1_i);
  assign w_n2    = f_lat(fpu_op2_i);
  assign w_maxn  = (w_n1 > w_n2) ? w_n1 : w_n2;
  assign w_start = rstn && (r_state == S_IDLE) &&
                   issue_i && (w_maxn != '0);

  // A lane counts as latched once its latency has passed (or it had none).
  assign w_lat1    = (r_n1 == '0) || (r_cnt > r_n1);
  assign w_lat2    = (r_n2 == '0) || (r_cnt > r_n2);
  assign w_release = (r_cnt == r_maxn);

  // Writeback entries targeting r0 are never forwarded from the keep set.
  always_comb begin
    w_keep_we = '0;
    for (int k = 0; k < 4; k++) begin
      w_keep_we[k] = wb_we_i[k] &&
                     (wb_reg_i[k*REG_W +: REG_W] != '0);
    end
  end

  // Stall/release handshake and result muxing toward the E/M register.
  always_comb begin
    float_stall_o = 1'b0;
    read_keep_o   = 1'b0;
    res_valid_o   = 1'b0;
    res1_o        = fpu_res1_i;
    res2_o        = fpu_res2_i;
    if (rstn) begin
      unique case (r_state)
        S_IDLE: begin
          float_stall_o = w_start;
          read_keep_o   = w_start;
          res_valid_o   = issue_i && (w_maxn == '0);
        end
        S_BUSY: begin
          float_stall_o = !w_release;
          res_valid_o   = w_release;
          if (w_lat1) res1_o = r_res1;
          if (w_lat2) res2_o = r_res2;
        end
        default: ;
      endcase
    end
  end

  assign fstalled_o  = rstn && (r_state == S_BUSY);
  assign keep_reg_o  = r_keep_reg;
  assign keep_we_o   = r_keep_we;
  assign keep_data_o = r_keep_data;

  // Sequencer FSM: count out the longest lane, capture each lane on time.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_n1        <= '0;
      r_n2        <= '0;
      r_maxn      <= '0;
      r_res1      <= '0;
      r_res2      <= '0;
      r_keep_reg  <= '0;
      r_keep_we   <= '0;
      r_keep_data <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_state     <= S_BUSY;
            r_cnt       <= LAT_W'(1);
            r_n1        <= w_n1;
            r_n2        <= w_n2;
            r_maxn      <= w_maxn;
            r_keep_reg  <= wb_reg_i;
            r_keep_we   <= w_keep_we;
            r_keep_data <= wb_data_i;
            if (w_n1 == '0) r_res1 <= fpu_res1_i;
            if (w_n2 == '0) r_res2 <= fpu_res2_i;
          end
        end
        S_BUSY: begin
          if (r_cnt == r_n1) r_res1 <= fpu_res1_i;
          if (r_cnt == r_n2) r_res2 <= fpu_res2_i;
          if (w_release) begin
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + LAT_W'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef FSTALL_PERF_EN
  logic [31:0] r_perf;

  // Saturating count of cycles spent requesting a float stall.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_perf <= '0;
    end else if (float_stall_o && (r_perf != 32'hFFFF_FFFF)) begin
      r_perf <= r_perf + 32'd1;
    end
  end

  assign perf_fstall_o = r_perf;
`endif

endmodule

// File: tb/tb_fpu_stall_seq_vliw.sv
// Self-checking bench for fpu_stall_seq_vliw.
// Table vectors, corner sequences, and a randomized transaction-level model.
module tb_fpu_stall_seq_vliw;
  localparam int DW = 32;
  localparam int RW = 6;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          issue = 1'b0;
  logic [4:0]    op1 = '0;
  logic [4:0]    op2 = '0;
  logic [DW-1:0] r1 = '0;
  logic [DW-1:0] r2 = '0;
  logic [4*RW-1:0] wbr = '0;
  logic [3:0]    wbwe = '0;
  logic [4*DW-1:0] wbd = '0;

  logic          stall, fst, rk, rv;
  logic [4*RW-1:0] kreg;
  logic [3:0]    kwe;
  logic [4*DW-1:0] kdata;
  logic [DW-1:0] o1, o2;
`ifdef FSTALL_PERF_EN
  logic [31:0]   perf;
`endif

  int checks = 0;
  int errs = 0;
  int exp_perf = 0;

  fpu_stall_seq_vliw dut (
    .clk(clk), .rstn(rstn), .issue_i(issue),
    .fpu_op1_i(op1), .fpu_op2_i(op2),
    .fpu_res1_i(r1), .fpu_res2_i(r2),
    .wb_reg_i(wbr), .wb_we_i(wbwe), .wb_data_i(wbd),
    .float_stall_o(stall), .fstalled_o(fst),
    .read_keep_o(rk), .keep_reg_o(kreg),
    .keep_we_o(kwe), .keep_data_o(kdata),
    .res1_o(o1), .res2_o(o2), .res_valid_o(rv)
`ifdef FSTALL_PERF_EN
    , .perf_fstall_o(perf)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [127:0] a,
                     input logic [127:0] e);
    checks++;
    if (a !== e) begin
      errs++;
      $display("FAIL %s: got %0h required %0h", nm, a, e);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  function automatic int lat(input logic [4:0] op);
    if (op == 5'b00001 || op == 5'b00011 || op == 5'b00101) return 1;
    if (op == 5'b00111) return 3;
    if (op == 5'b01101) return 2;
    return 0;
  endfunction

  typedef struct {
    logic [4:0]  op1;
    logic [4:0]  op2;
    int          n;
    logic [31:0] e1;
    logic [31:0] e2;
  } vec_t;

  vec_t vt[7];

  logic [4:0] codes[8];
  logic [31:0] h1[8];
  logic [31:0] h2[8];
  logic [4*RW-1:0] ek_reg;
  logic [3:0] ek_we;
  logic [4*DW-1:0] ek_data;
  int n1, n2, mx;
  logic iss;
  logic [31:0] e1, e2;

  task automatic rand_wb();
    for (int k = 0; k < 4; k++) begin
      wbr[k*RW +: RW] = RW'($urandom_range(0, 3));
      wbd[k*DW +: DW] = $urandom;
    end
    wbwe = 4'($urandom);
  endtask

  initial begin
    vt[0] = '{5'b00001, 5'b01001, 1, 32'h101, 32'h200};
    vt[1] = '{5'b00111, 5'b01101, 3, 32'h103, 32'h202};
    vt[2] = '{5'b01001, 5'b00000, 0, 32'h100, 32'h200};
    vt[3] = '{5'b00011, 5'b00011, 1, 32'h101, 32'h201};
    vt[4] = '{5'b00101, 5'b00111, 3, 32'h101, 32'h203};
    vt[5] = '{5'b01101, 5'b00000, 2, 32'h102, 32'h200};
    vt[6] = '{5'b11111, 5'b00010, 0, 32'h100, 32'h200};
    codes = '{5'b00001, 5'b00011, 5'b00101, 5'b00111,
              5'b01101, 5'b00000, 5'b01001, 5'b11111};

    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    r1 = 32'h1234;
    r2 = 32'h5678;
    @(negedge clk);
    chk("rst_stall", 128'(stall), 128'(1'b0));
    chk("rst_fst", 128'(fst), 128'(1'b0));
    chk("rst_rk", 128'(rk), 128'(1'b0));
    chk("rst_rv", 128'(rv), 128'(1'b0));
    chk("rst_kwe", 128'(kwe), 128'(4'h0));
    chk("rst_kreg", 128'(kreg), 128'(24'h0));
    chk("rst_kdata", 128'(kdata), 128'(128'h0));
    chk("rst_res1", 128'(o1), 128'(32'h1234));
    chk("rst_res2", 128'(o2), 128'(32'h5678));
`ifdef FSTALL_PERF_EN
    chk("rst_perf", 128'(perf), 128'(32'h0));
`endif
    nxt();

    for (int i = 0; i < 7; i++) begin
      issue = 1'b1;
      op1 = vt[i].op1;
      op2 = vt[i].op2;
      r1 = 32'h100;
      r2 = 32'h200;
      @(negedge clk);
      chk("tab_stall0", 128'(stall), 128'(vt[i].n > 0));
      chk("tab_rk0", 128'(rk), 128'(vt[i].n > 0));
      chk("tab_rv0", 128'(rv), 128'(vt[i].n == 0));
      chk("tab_fst0", 128'(fst), 128'(1'b0));
      if (vt[i].n == 0) begin
        chk("tab_res1_0", 128'(o1), 128'(vt[i].e1));
        chk("tab_res2_0", 128'(o2), 128'(vt[i].e2));
      end
      for (int t = 1; t <= vt[i].n; t++) begin
        nxt();
        r1 = 32'h100 + 32'(t);
        r2 = 32'h200 + 32'(t);
        @(negedge clk);
        chk("tab_stall", 128'(stall), 128'(t < vt[i].n));
        chk("tab_fst", 128'(fst), 128'(1'b1));
        chk("tab_rk", 128'(rk), 128'(1'b0));
        chk("tab_rv", 128'(rv), 128'(t == vt[i].n));
        if (t == vt[i].n) begin
          chk("tab_res1", 128'(o1), 128'(vt[i].e1));
          chk("tab_res2", 128'(o2), 128'(vt[i].e2));
        end
      end
      nxt();
      issue = 1'b0;
      @(negedge clk);
      chk("tab_idle_stall", 128'(stall), 128'(1'b0));
      chk("tab_idle_fst", 128'(fst), 128'(1'b0));
      chk("tab_idle_rv", 128'(rv), 128'(1'b0));
      nxt();
    end

    issue = 1'b1;
    op1 = 5'b00111;
    op2 = 5'b00000;
    wbr = {6'd5, 6'd0, 6'd7, 6'd9};
    wbwe = 4'b1111;
    wbd = {32'hAAAA_0001, 32'hBBBB_0002, 32'hCCCC_0003, 32'hDDDD_0004};
    @(negedge clk);
    chk("keep_stall0", 128'(stall), 128'(1'b1));
    for (int t = 1; t <= 3; t++) begin
      nxt();
      wbr = {6'd1, 6'd2, 6'd3, 6'd4};
      wbwe = 4'b0000;
      wbd = '1;
      @(negedge clk);
      chk("keep_fst", 128'(fst), 128'(1'b1));
      chk("keep_we", 128'(kwe), 128'(4'b1011));
      chk("keep_reg", 128'(kreg), 128'({6'd5, 6'd0, 6'd7, 6'd9}));
      chk("keep_data", 128'(kdata),
          128'({32'hAAAA_0001, 32'hBBBB_0002,
                32'hCCCC_0003, 32'hDDDD_0004}));
    end
    nxt();
    issue = 1'b0;
    @(negedge clk);
    chk("keep_hold_fst", 128'(fst), 128'(1'b0));
    chk("keep_hold_we", 128'(kwe), 128'(4'b1011));
    nxt();

    issue = 1'b1;
    op1 = 5'b00111;
    op2 = 5'b00000;
    wbr = {6'd1, 6'd2, 6'd3, 6'd4};
    wbwe = 4'b1111;
    nxt();
    nxt();
    rstn = 1'b0;
    nxt();
    rstn = 1'b1;
    issue = 1'b0;
    @(negedge clk);
    chk("mid_rst_stall", 128'(stall), 128'(1'b0));
    chk("mid_rst_fst", 128'(fst), 128'(1'b0));
    chk("mid_rst_kwe", 128'(kwe), 128'(4'h0));
    chk("mid_rst_rv", 128'(rv), 128'(1'b0));
    nxt();
    issue = 1'b1;
    op1 = 5'b00001;
    op2 = 5'b01001;
    r1 = 32'hF00D_0000;
    @(negedge clk);
    chk("mid_rst_fadd_stall", 128'(stall), 128'(1'b1));
    nxt();
    issue = 1'b0;
    r1 = 32'hF00D_0001;
    @(negedge clk);
    chk("mid_rst_fadd_stall1", 128'(stall), 128'(1'b0));
    chk("mid_rst_fadd_rv", 128'(rv), 128'(1'b1));
    chk("mid_rst_fadd_res1", 128'(o1), 128'(32'hF00D_0001));
    nxt();

    rstn = 1'b0;
    issue = 1'b0;
    nxt();
    rstn = 1'b1;
    begin
      logic [5:0] pat;
      pat = 6'b011101;
      for (int c = 0; c < 6; c++) begin
        issue = 1'b1;
        op1 = (c < 2) ? 5'b00011 : 5'b00111;
        op2 = 5'b00000;
        @(negedge clk);
        chk("b2b_stall", 128'(stall), 128'(pat[c]));
        nxt();
      end
    end
    issue = 1'b0;
`ifdef FSTALL_PERF_EN
    @(negedge clk);
    chk("b2b_perf", 128'(perf), 128'(32'd4));
    nxt();
`endif
    exp_perf = 4;
    ek_reg = {6'd1, 6'd2, 6'd3, 6'd4};
    ek_we = 4'b1111;
    ek_data = wbd;

    for (int tr = 0; tr < 400; tr++) begin
      iss = ($urandom_range(0, 3) != 0);
      issue = iss;
      op1 = codes[$urandom_range(0, 7)];
      op2 = codes[$urandom_range(0, 7)];
      rand_wb();
      r1 = $urandom;
      r2 = $urandom;
      h1[0] = r1;
      h2[0] = r2;
      n1 = lat(op1);
      n2 = lat(op2);
      mx = (n1 > n2) ? n1 : n2;
      if (!iss) mx = 0;
      @(negedge clk);
      chk("rnd_fst0", 128'(fst), 128'(1'b0));
      chk("rnd_stall0", 128'(stall), 128'(iss && mx > 0));
      chk("rnd_rk0", 128'(rk), 128'(iss && mx > 0));
      chk("rnd_rv0", 128'(rv), 128'(iss && mx == 0));
      chk("rnd_kwe0", 128'(kwe), 128'(ek_we));
      chk("rnd_kdata0", 128'(kdata), 128'(ek_data));
      if (!(iss && mx > 0)) begin
        chk("rnd_res1_0", 128'(o1), 128'(h1[0]));
        chk("rnd_res2_0", 128'(o2), 128'(h2[0]));
      end else begin
        exp_perf++;
        ek_reg = wbr;
        ek_data = wbd;
        for (int k = 0; k < 4; k++)
          ek_we[k] = wbwe[k] && (wbr[k*RW +: RW] != 0);
      end
      for (int t = 1; t <= mx; t++) begin
        nxt();
        issue = 1'($urandom);
        op1 = codes[$urandom_range(0, 7)];
        op2 = codes[$urandom_range(0, 7)];
        rand_wb();
        r1 = $urandom;
        r2 = $urandom;
        h1[t] = r1;
        h2[t] = r2;
        e1 = (n1 == 0) ? h1[0] : ((t > n1) ? h1[n1] : r1);
        e2 = (n2 == 0) ? h2[0] : ((t > n2) ? h2[n2] : r2);
        @(negedge clk);
        chk("rnd_fst", 128'(fst), 128'(1'b1));
        chk("rnd_stall", 128'(stall), 128'(t < mx));
        chk("rnd_rk", 128'(rk), 128'(1'b0));
        chk("rnd_rv", 128'(rv), 128'(t == mx));
        chk("rnd_res1", 128'(o1), 128'(e1));
        chk("rnd_res2", 128'(o2), 128'(e2));
        chk("rnd_kreg", 128'(kreg), 128'(ek_reg));
        chk("rnd_kwe", 128'(kwe), 128'(ek_we));
        chk("rnd_kdata", 128'(kdata), 128'(ek_data));
        if (t < mx) exp_perf++;
      end
      nxt();
    end

    issue = 1'b0;
    @(negedge clk);
    chk("end_fst", 128'(fst), 128'(1'b0));
`ifdef FSTALL_PERF_EN
    chk("end_perf", 128'(perf), 128'(exp_perf));
`endif
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, errs);
    $finish;
  end
endmodule
